// File: rtl/aud_i2s_recorder.sv
// I2S capture of the left ADC channel from a codec-mastered bus into SRAM at incrementing addresses.
// Start/pause/stop pulses steer the recorder; o_full latches once the last address has been written.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | not recording; address at 0 or held after a full buffer
// WAIT_LR | armed, waiting for the start of a left frame (ADCLRCK fall)
// SKIP    | discarding the I2S one-bit delay slot
// SHIFT   | shifting in DATA_W bits MSB first on BCLK rises
// WRITE   | one-cycle SRAM write strobe, then advance the address
// PAUSED  | recording suspended, address held for resume
module aud_i2s_recorder #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 20,
    parameter logic [ADDR_W-1:0] MAX_ADDR = {ADDR_W{1'b1}}
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_stop,
    input  logic              i_aud_bclk,
    input  logic              i_aud_adclrck,
    input  logic              i_aud_adcdat,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_data,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_last_addr,
    output logic              o_busy,
    output logic              o_full
);

    localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT_LR = 3'd1,
        S_SKIP    = 3'd2,
        S_SHIFT   = 3'd3,
        S_WRITE   = 3'd4,
        S_PAUSED  = 3'd5
    } state_t;

    state_t state, state_nxt;

    logic [2:0] bclk_sync;
    logic [2:0] lrc_sync;
    logic [1:0] dat_sync;
    logic       bclk_rise;
    logic       lrc_fall;
    logic       dat_bit;

    logic [DATA_W-1:0] shreg, shreg_nxt;
    logic [DATA_W-1:0] data_reg, data_nxt;
    logic [CNT_W-1:0]  bit_cnt, cnt_nxt;
    logic [ADDR_W-1:0] addr, addr_nxt;
    logic [ADDR_W-1:0] last_addr, last_nxt;
    logic              full, full_nxt;
    logic              pause_pend, pend_nxt;
    logic              wr_en;

    // Third flop of BCLK/LRCK exists only for edge detection.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bclk_sync <= '0;
            lrc_sync  <= '0;
            dat_sync  <= '0;
        end else begin
            bclk_sync <= {bclk_sync[1:0], i_aud_bclk};
            lrc_sync  <= {lrc_sync[1:0], i_aud_adclrck};
            dat_sync  <= {dat_sync[0], i_aud_adcdat};
        end
    end

    assign bclk_rise = bclk_sync[1] & ~bclk_sync[2];
    assign lrc_fall  = ~lrc_sync[1] & lrc_sync[2];
    assign dat_bit   = dat_sync[1];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= S_IDLE;
            shreg      <= '0;
            data_reg   <= '0;
            bit_cnt    <= '0;
            addr       <= '0;
            last_addr  <= '0;
            full       <= 1'b0;
            pause_pend <= 1'b0;
        end else begin
            state      <= state_nxt;
            shreg      <= shreg_nxt;
            data_reg   <= data_nxt;
            bit_cnt    <= cnt_nxt;
            addr       <= addr_nxt;
            last_addr  <= last_nxt;
            full       <= full_nxt;
            pause_pend <= pend_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        data_nxt  = data_reg;
        cnt_nxt   = bit_cnt;
        addr_nxt  = addr;
        last_nxt  = last_addr;
        full_nxt  = full;
        pend_nxt  = pause_pend;
        wr_en     = 1'b0;

        // Stop wins over everything, including a write that would otherwise fire this cycle.
        if (i_stop) begin
            state_nxt = S_IDLE;
            addr_nxt  = '0;
            full_nxt  = 1'b0;
            pend_nxt  = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_start && !full) state_nxt = S_WAIT_LR;
                end
                S_WAIT_LR: begin
                    if (i_pause) pend_nxt = 1'b1;
                    if (lrc_fall) state_nxt = S_SKIP;
                end
                S_SKIP: begin
                    if (i_pause) pend_nxt = 1'b1;
                    if (bclk_rise) begin
                        state_nxt = S_SHIFT;
                        cnt_nxt   = '0;
                    end
                end
                S_SHIFT: begin
                    if (i_pause) pend_nxt = 1'b1;
                    if (bclk_rise) begin
                        shreg_nxt = {shreg[DATA_W-2:0], dat_bit};
                        cnt_nxt   = bit_cnt + 1'b1;
                        if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                            data_nxt  = {shreg[DATA_W-2:0], dat_bit};
                            state_nxt = S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    wr_en    = 1'b1;
                    last_nxt = addr;
                    if (addr == MAX_ADDR) begin
                        full_nxt  = 1'b1;
                        pend_nxt  = 1'b0;
                        state_nxt = S_IDLE;
                    end else begin
                        addr_nxt = addr + 1'b1;
                        if (pause_pend || i_pause) begin
                            pend_nxt  = 1'b0;
                            state_nxt = S_PAUSED;
                        end else begin
                            state_nxt = S_WAIT_LR;
                        end
                    end
                end
                S_PAUSED: begin
                    if (i_start) state_nxt = S_WAIT_LR;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    assign o_addr      = addr;
    assign o_data      = data_reg;
    assign o_wr_en     = wr_en;
    assign o_last_addr = last_addr;
    assign o_full      = full;
    assign o_busy      = (state == S_WAIT_LR) || (state == S_SKIP) ||
                         (state == S_SHIFT)   || (state == S_WRITE);

endmodule

// File: tb/tb_aud_i2s_recorder.sv
// Bench for aud_i2s_recorder: an I2S codec model drives frames while a frame-level recorder model
// predicts writes into a scoreboard queue that an independent monitor drains on each o_wr_en.
module tb_aud_i2s_recorder;

    localparam int          DATA_W = 16;
    localparam int          ADDR_W = 20;
    localparam logic [19:0] MAX    = 20'h7;
    localparam int          SLOT   = 20;

    logic              clk = 1'b0;
    logic              rst, start, pause, stop;
    logic              aud_bclk, aud_lrc, aud_dat;
    logic [ADDR_W-1:0] addr, last_addr;
    logic [DATA_W-1:0] data;
    logic              wr_en, busy, full;

    aud_i2s_recorder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_ADDR(MAX)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_pause      (pause),
        .i_stop       (stop),
        .i_aud_bclk   (aud_bclk),
        .i_aud_adclrck(aud_lrc),
        .i_aud_adcdat (aud_dat),
        .o_addr       (addr),
        .o_data       (data),
        .o_wr_en      (wr_en),
        .o_last_addr  (last_addr),
        .o_busy       (busy),
        .o_full       (full)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [35:0] exp_q[$];

    // Recorder model: mode 0 idle, 1 recording, 2 paused
    int          m_mode = 0;
    logic [19:0] m_addr = '0;
    logic [19:0] m_last = '0;
    bit          m_full = 0;
    bit          m_pend = 0;
    bit          m_cap  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    logic prev_wr = 1'b0;
    always @(negedge clk) begin
        logic [35:0] e;
        if (wr_en) begin
            check("wr_back_to_back", {31'd0, prev_wr}, 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual addr=%h data=%h required=no_write", addr, data);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", {12'd0, addr}, {12'd0, e[35:16]});
                check("wr_data", {16'd0, data}, {16'd0, e[15:0]});
            end
        end
        prev_wr = wr_en;
    end

    task automatic model_cmd(input int cmd);
        case (cmd)
            1: if ((m_mode == 0 && !m_full) || m_mode == 2) m_mode = 1;
            2: if (m_mode == 1) m_pend = 1;
            3, 5: begin
                m_mode = 0; m_addr = '0; m_full = 0; m_pend = 0; m_cap = 0;
            end
            4: begin
                m_mode = 0; m_addr = '0; m_last = '0; m_full = 0; m_pend = 0; m_cap = 0;
            end
            default: ;
        endcase
    endtask

    task automatic model_word_done(input logic [15:0] word);
        if (m_cap) begin
            exp_q.push_back({m_addr, word});
            m_last = m_addr;
            if (m_addr == MAX) begin
                m_full = 1; m_mode = 0; m_pend = 0;
            end else begin
                m_addr = m_addr + 1;
                if (m_pend) begin
                    m_mode = 2; m_pend = 0;
                end
            end
        end
        m_cap = 0;
    endtask

    task automatic drive_cmd(input int cmd, input bit val);
        case (cmd)
            1: start = val;
            2: pause = val;
            3: stop  = val;
            4: rst   = val;
            5: begin stop = val; start = val; end
            default: ;
        endcase
    endtask

    // One I2S frame: left word in slots 1..16 after the delay slot, random filler elsewhere.
    task automatic run_frame(input logic [15:0] word, input int cslot, input int cmd);
        for (int s = 0; s < 2 * SLOT; s++) begin
            aud_bclk = 1'b0;
            aud_lrc  = (s >= SLOT);
            aud_dat  = (s >= 1 && s <= DATA_W) ? word[DATA_W - s] : 1'($urandom);
            if (s == 0) m_cap = (m_mode == 1);
            if (s == DATA_W) model_word_done(word);
            if (s == cslot && cmd != 0) begin
                drive_cmd(cmd, 1'b1);
                model_cmd(cmd);
                @(negedge clk);
                drive_cmd(cmd, 1'b0);
                if (cmd == 4) begin
                    check("rst_last_addr", {12'd0, last_addr}, 32'd0);
                    check("rst_busy", {31'd0, busy}, 32'd0);
                end
                repeat (3) @(negedge clk);
            end else begin
                repeat (4) @(negedge clk);
            end
            aud_bclk = 1'b1;
            repeat (4) @(negedge clk);
        end
        check("addr", {12'd0, addr}, {12'd0, m_addr});
        check("last_addr", {12'd0, last_addr}, {12'd0, m_last});
        check("full", {31'd0, full}, {31'd0, m_full});
        check("busy", {31'd0, busy}, {31'd0, (m_mode == 1)});
    endtask

    function automatic logic [15:0] rnd16();
        return 16'($urandom);
    endfunction

    initial begin
        int r, cmd, cs;
        rst = 1'b1; start = 1'b0; pause = 1'b0; stop = 1'b0;
        aud_bclk = 1'b0; aud_lrc = 1'b1; aud_dat = 1'b0;
        repeat (5) @(negedge clk);
        check("reset_addr", {12'd0, addr}, 32'd0);
        check("reset_data", {16'd0, data}, 32'd0);
        check("reset_wr_en", {31'd0, wr_en}, 32'd0);
        check("reset_last_addr", {12'd0, last_addr}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_full", {31'd0, full}, 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Basic capture of two known words
        run_frame(rnd16(), 24, 1);
        run_frame(16'hA5C3, 0, 0);
        run_frame(16'h1234, 0, 0);
        // Stop, then start mid-left-frame: partial frame must not be written
        run_frame(rnd16(), 24, 3);
        run_frame(rnd16(), 8, 1);
        run_frame(rnd16(), 0, 0);
        // Pause mid-word: word still written, then three silent frames, resume
        run_frame(16'h00FF, 10, 2);
        repeat (3) run_frame(rnd16(), 0, 0);
        run_frame(rnd16(), 5, 1);
        repeat (3) run_frame(rnd16(), 0, 0);
        // Stop mid-word at address 5
        run_frame(rnd16(), 10, 3);
        // Fill to MAX, then start ignored until stop
        run_frame(rnd16(), 24, 1);
        repeat (8) run_frame(rnd16(), 0, 0);
        run_frame(rnd16(), 24, 1);
        run_frame(rnd16(), 0, 0);
        run_frame(rnd16(), 24, 3);
        run_frame(rnd16(), 24, 1);
        run_frame(rnd16(), 0, 0);
        // Reset mid-frame, then stop+start together mid-word
        run_frame(rnd16(), 9, 4);
        run_frame(rnd16(), 24, 1);
        run_frame(rnd16(), 10, 5);
        run_frame(rnd16(), 0, 0);

        // Randomized command traffic
        for (int f = 0; f < 40; f++) begin
            r   = $urandom_range(0, 9);
            cmd = (r < 5) ? 0 : (r < 7) ? 1 : (r < 8) ? 2 : (r == 8) ? 3 :
                  (($urandom_range(0, 3) == 0) ? 4 : 5);
            cs  = ($urandom_range(0, 1) == 1) ? $urandom_range(3, 13) : $urandom_range(22, 37);
            run_frame(rnd16(), cs, cmd);
        end

        run_frame(rnd16(), 24, 3);
        repeat (20) @(negedge clk);
        check("pending_writes", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
